// File: rtl/hdmi_pkg.sv
// Shared types and timing constants for the HDMI period scheduler.
package hdmi_pkg;

   typedef enum logic [2:0] {
      CONTROL         = 3'd0,
      VIDEO_PREAMBLE  = 3'd1,
      VIDEO_GUARD     = 3'd2,
      VIDEO_DATA      = 3'd3,
      ISLAND_PREAMBLE = 3'd4,
      ISLAND_GUARD    = 3'd5,
      ISLAND_DATA     = 3'd6
   } mode_t;

   typedef enum logic [2:0] {
      IDLE,
      I_PRE,
      I_GUARD_LEAD,
      I_DATA,
      I_GUARD_TRAIL
   } island_state_t;

   localparam int unsigned PREAMBLE_LEN = 8;
   localparam int unsigned GUARD_LEN    = 2;
   localparam int unsigned PACKET_LEN   = 32;
   localparam logic [3:0]  CTL_VIDEO    = 4'b0001;
   localparam logic [3:0]  CTL_ISLAND   = 4'b0101;

endpackage

// File: rtl/hdmi_raster_counter.sv
// Raster position and sync generation; also exposes the next pixel position
// so the scheduler can register its outputs in step with cx/cy.
module hdmi_raster_counter #(
   parameter int unsigned H_TOTAL      = 800,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned V_TOTAL      = 525,
   parameter int unsigned H_SYNC_START = 656,
   parameter int unsigned H_SYNC_END   = 752,
   parameter int unsigned V_SYNC_START = 490,
   parameter int unsigned V_SYNC_END   = 492,
   parameter int unsigned SYNC_ACTIVE  = 0
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   output logic [11:0] cx,
   output logic [11:0] cy,
   output logic [11:0] cx_next,
   output logic [11:0] cy_next,
   output logic        hsync,
   output logic        vsync
);

   localparam logic [11:0] HT_M1 = 12'(H_TOTAL - 1);
   localparam logic [11:0] VT_M1 = 12'(V_TOTAL - 1);
   localparam logic [11:0] VA    = 12'(V_ACTIVE);
   localparam logic [11:0] HSS   = 12'(H_SYNC_START);
   localparam logic [11:0] HSE   = 12'(H_SYNC_END);
   localparam logic [11:0] VSS   = 12'(V_SYNC_START);
   localparam logic [11:0] VSE   = 12'(V_SYNC_END);
   localparam logic        SYNC_LVL = 1'(SYNC_ACTIVE);

   logic [11:0] cx_q, cx_d;
   logic [11:0] cy_q, cy_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;

   always_comb begin
      cx_d = cx_q + 12'd1;
      cy_d = cy_q;
      if (cx_q == HT_M1) begin
         cx_d = '0;
         cy_d = (cy_q == VT_M1) ? '0 : cy_q + 12'd1;
      end
      hsync_d = (cx_d >= HSS && cx_d < HSE) ? SYNC_LVL : ~SYNC_LVL;
      vsync_d = (cy_d >= VSS && cy_d < VSE) ? SYNC_LVL : ~SYNC_LVL;
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         cx_q    <= '0;
         cy_q    <= VA;
         hsync_q <= ~SYNC_LVL;
         vsync_q <= ~SYNC_LVL;
      end else begin
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign cx      = cx_q;
   assign cy      = cy_q;
   assign cx_next = cx_d;
   assign cy_next = cy_d;
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencing: video preamble/guard/data and data islands
// in horizontal blanking with a packet-slot handshake to the packet source.
module hdmi_period_scheduler #(
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned H_TOTAL      = 800,
   parameter int unsigned H_SYNC_START = 656,
   parameter int unsigned H_SYNC_END   = 752,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned V_TOTAL      = 525,
   parameter int unsigned V_SYNC_START = 490,
   parameter int unsigned V_SYNC_END   = 492,
   parameter int unsigned SYNC_ACTIVE  = 0,
   parameter int unsigned ISLAND_GAP   = 4,
   parameter int unsigned MAX_PACKETS  = 2
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        packet_avail,
   output logic [11:0] cx,
   output logic [11:0] cy,
   output logic [2:0]  mode,
   output logic [3:0]  ctl,
   output logic        hsync,
   output logic        vsync,
   output logic        packet_start,
   output logic [4:0]  packet_beat
);

   import hdmi_pkg::*;

   if (H_ACTIVE + ISLAND_GAP + 12 + 32 * MAX_PACKETS + 4 > H_TOTAL - 10 ||
       MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : g_bad_timing
      $fatal(1, "hdmi_period_scheduler: island does not fit in horizontal blanking");
   end

   localparam logic [11:0] VT_M1      = 12'(V_TOTAL - 1);
   localparam logic [11:0] HA         = 12'(H_ACTIVE);
   localparam logic [11:0] VA         = 12'(V_ACTIVE);
   localparam logic [11:0] VP_FIRST   = 12'(H_TOTAL - 10);
   localparam logic [11:0] VP_LAST    = 12'(H_TOTAL - 3);
   localparam logic [11:0] VG_FIRST   = 12'(H_TOTAL - 2);
   localparam logic [11:0] DECIDE     = 12'(H_ACTIVE + ISLAND_GAP - 1);
   localparam logic [2:0]  PRE_LAST   = 3'(PREAMBLE_LEN - 1);
   localparam logic [2:0]  GUARD_LAST = 3'(GUARD_LEN - 1);
   localparam logic [4:0]  BEAT_LAST  = 5'(PACKET_LEN - 1);
   localparam logic [4:0]  MAX_K      = 5'(MAX_PACKETS);

   logic [11:0]   cx_next, cy_next, cy_after;
   logic          next_line_active;
   island_state_t state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [4:0]    k_q, k_d;
   logic [4:0]    beat_q, beat_d;
   logic          start_q, start_d;
   mode_t         mode_q, mode_d;
   logic [3:0]    ctl_q, ctl_d;

   hdmi_raster_counter #(
      .H_TOTAL      (H_TOTAL),
      .V_ACTIVE     (V_ACTIVE),
      .V_TOTAL      (V_TOTAL),
      .H_SYNC_START (H_SYNC_START),
      .H_SYNC_END   (H_SYNC_END),
      .V_SYNC_START (V_SYNC_START),
      .V_SYNC_END   (V_SYNC_END),
      .SYNC_ACTIVE  (SYNC_ACTIVE)
   ) u_raster (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .cx        (cx),
      .cy        (cy),
      .cx_next   (cx_next),
      .cy_next   (cy_next),
      .hsync     (hsync),
      .vsync     (vsync)
   );

   // Island FSM: decisions use the current pixel; state_d describes the next one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      beat_d  = '0;
      start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cx == DECIDE && packet_avail) begin
               state_d = I_PRE;
               cnt_d   = '0;
            end
         end
         I_PRE: begin
            if (cnt_q == PRE_LAST) begin
               state_d = I_GUARD_LEAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         I_GUARD_LEAD: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = I_DATA;
               start_d = 1'b1;
               k_d     = 5'd1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         I_DATA: begin
            if (beat_q == BEAT_LAST) begin
               if (packet_avail && k_q < MAX_K) begin
                  start_d = 1'b1;
                  k_d     = k_q + 5'd1;
               end else begin
                  state_d = I_GUARD_TRAIL;
                  cnt_d   = '0;
               end
            end else begin
               beat_d = beat_q + 5'd1;
            end
         end
         I_GUARD_TRAIL: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cy_after         = (cy_next == VT_M1) ? '0 : cy_next + 12'd1;
      next_line_active = (cy_after < VA);
      mode_d           = CONTROL;
      ctl_d            = '0;
      case (state_d)
         I_PRE: begin
            mode_d = ISLAND_PREAMBLE;
            ctl_d  = CTL_ISLAND;
         end
         I_GUARD_LEAD, I_GUARD_TRAIL: mode_d = ISLAND_GUARD;
         I_DATA:                      mode_d = ISLAND_DATA;
         default: begin
            if (cx_next < HA && cy_next < VA) begin
               mode_d = VIDEO_DATA;
            end else if (next_line_active && cx_next >= VP_FIRST && cx_next <= VP_LAST) begin
               mode_d = VIDEO_PREAMBLE;
               ctl_d  = CTL_VIDEO;
            end else if (next_line_active && cx_next >= VG_FIRST) begin
               mode_d = VIDEO_GUARD;
            end
         end
      endcase
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         beat_q  <= '0;
         start_q <= 1'b0;
         mode_q  <= CONTROL;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         beat_q  <= beat_d;
         start_q <= start_d;
         mode_q  <= mode_d;
         ctl_q   <= ctl_d;
      end
   end

   assign mode         = mode_q;
   assign ctl          = ctl_q;
   assign packet_start = start_q;
   assign packet_beat  = beat_q;

endmodule
